riscv_wb_arbiter: RTL and testbench

RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

---
 rtl/riscv_wb_arbiter_pkg.sv | 14 +
 rtl/riscv_wb_arbiter_if.sv | 30 +++
 rtl/riscv_wb_arbiter_rr_arb2.sv | 35 +++
 rtl/riscv_wb_arbiter.sv | 100 ++++++++++
 tb/tb_riscv_wb_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_wb_arbiter_pkg.sv
// Shared writeback constants: register-file write enable encoding and writeback source ids.
package riscv_wb_arbiter_pkg;

  typedef enum logic {
    RF_NO_WRITE = 1'b0,
    RF_WRITE    = 1'b1
  } rf_wen_e;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/riscv_wb_arbiter_if.sv
// Writeback bus: two valid/ready request channels (ALU, LSU) plus the register-file write port.
interface riscv_wb_arbiter_if #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned ADDR_LENGTH = 5
);
  import riscv_wb_arbiter_pkg::*;

  logic                   req0_valid;
  logic [ADDR_LENGTH-1:0] req0_addr;
  logic [WORD_LENGTH-1:0] req0_data;
  logic                   req0_ready;
  logic                   req1_valid;
  logic [ADDR_LENGTH-1:0] req1_addr;
  logic [WORD_LENGTH-1:0] req1_data;
  logic                   req1_ready;
  rf_wen_e                rf_write_en;
  logic [ADDR_LENGTH-1:0] rf_write_addr;
  logic [WORD_LENGTH-1:0] rf_data;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, rf_write_en, rf_write_addr, rf_data
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, rf_write_en, rf_write_addr, rf_data
  );

endinterface

// File: rtl/riscv_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-granted pointer moves only when a grant is issued.
module riscv_rr_arb2
  import riscv_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic grant0,
  output logic grant1
);

  wb_src_e last_q, last_d;

  // A grant always implies acceptance, since ready is only raised for a valid requester.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || (last_q == WB_SRC_LSU));
    grant1 = req1_valid && (!req0_valid || (last_q == WB_SRC_ALU));
    last_d = last_q;
    if (grant1) begin
      last_d = WB_SRC_LSU;
    end else if (grant0) begin
      last_d = WB_SRC_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= WB_SRC_ALU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter with registered RF write port and optional pending-register scoreboard
// (enabled by defining RISCV_WB_SCOREBOARD_EN).
module riscv_wb_arbiter
  import riscv_wb_arbiter_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned ADDR_LENGTH = 5,
  parameter int unsigned NUM_REGS    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  riscv_wb_arbiter_if.slave      wb,
  input  logic                   mark_valid,
  input  logic [ADDR_LENGTH-1:0] mark_addr,
  input  logic [ADDR_LENGTH-1:0] query_addr1,
  input  logic [ADDR_LENGTH-1:0] query_addr2,
  output logic                   busy1,
  output logic                   busy2
);

  logic                   grant0, grant1;
  logic                   accept;
  logic [ADDR_LENGTH-1:0] sel_addr;
  logic [WORD_LENGTH-1:0] sel_data;
  rf_wen_e                wen_q;
  logic [ADDR_LENGTH-1:0] addr_q;
  logic [WORD_LENGTH-1:0] data_q;

  riscv_rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (wb.req0_valid),
    .req1_valid (wb.req1_valid),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  assign wb.req0_ready = grant0;
  assign wb.req1_ready = grant1;

  always_comb begin
    accept   = grant0 || grant1;
    sel_addr = grant1 ? wb.req1_addr : wb.req0_addr;
    sel_data = grant1 ? wb.req1_data : wb.req0_data;
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q  <= RF_NO_WRITE;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wen_q <= (accept && (sel_addr != '0)) ? RF_WRITE : RF_NO_WRITE;
      if (accept) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
    end
  end

  assign wb.rf_write_en   = wen_q;
  assign wb.rf_write_addr = addr_q;
  assign wb.rf_data       = data_q;

`ifdef RISCV_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] sb_q, sb_d;

  // Clear first so that a same-cycle mark of the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (accept) begin
      sb_d[sel_addr] = 1'b0;
    end
    if (mark_valid && (mark_addr != '0)) begin
      sb_d[mark_addr] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign busy1 = (query_addr1 != '0) && sb_q[query_addr1];
  assign busy2 = (query_addr2 != '0) && sb_q[query_addr2];
`else
  logic [NUM_REGS-1:0] unused_sb;
  logic                unused_in;
  assign unused_sb = '0;
  assign unused_in = ^{mark_valid, mark_addr, query_addr1, query_addr2};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed self-checking bench for riscv_wb_arbiter; busy expectations follow the build config.
module tb_riscv_wb_arbiter;
  import riscv_wb_arbiter_pkg::*;

`ifdef RISCV_WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       mark_valid;
  logic [4:0] mark_addr;
  logic [4:0] query_addr1;
  logic [4:0] query_addr2;
  logic       busy1;
  logic       busy2;
  int         n_vec;
  int         n_err;

  riscv_wb_arbiter_if #(.WORD_LENGTH(32), .ADDR_LENGTH(5)) wb ();

  riscv_wb_arbiter #(.WORD_LENGTH(32), .ADDR_LENGTH(5), .NUM_REGS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb),
    .mark_valid  (mark_valid),
    .mark_addr   (mark_addr),
    .query_addr1 (query_addr1),
    .query_addr2 (query_addr2),
    .busy1       (busy1),
    .busy2       (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.req0_valid = 1'b0;
    wb.req1_valid = 1'b0;
    mark_valid    = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    idle();
    wb.req0_addr = '0; wb.req0_data = '0;
    wb.req1_addr = '0; wb.req1_data = '0;
    mark_addr = '0; query_addr1 = '0; query_addr2 = '0;
    tick();
    tick();
    chk("rst_wen", 32'(wb.rf_write_en), 32'(RF_NO_WRITE));
    chk("rst_addr", 32'(wb.rf_write_addr), 32'h0);
    chk("rst_data", wb.rf_data, 32'h0);
    rst = 1'b0;
    #1;
    chk("idle_rdy0", 32'(wb.req0_ready), 32'h0);
    chk("idle_rdy1", 32'(wb.req1_ready), 32'h0);

    // Both valid three cycles: LSU, ALU, LSU.
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd1; wb.req0_data = 32'h0000_00A1;
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd2; wb.req1_data = 32'h0000_00B2;
    #1;
    chk("rr1_rdy1", 32'(wb.req1_ready), 32'h1);
    chk("rr1_rdy0", 32'(wb.req0_ready), 32'h0);
    tick();
    chk("rr1_addr", 32'(wb.rf_write_addr), 32'd2);
    chk("rr1_data", wb.rf_data, 32'hB2);
    chk("rr2_rdy0", 32'(wb.req0_ready), 32'h1);
    chk("rr2_rdy1", 32'(wb.req1_ready), 32'h0);
    tick();
    chk("rr2_addr", 32'(wb.rf_write_addr), 32'd1);
    chk("rr2_data", wb.rf_data, 32'hA1);
    chk("rr3_rdy1", 32'(wb.req1_ready), 32'h1);
    chk("rr3_rdy0", 32'(wb.req0_ready), 32'h0);
    tick();
    idle();
    chk("rr3_addr", 32'(wb.rf_write_addr), 32'd2);
    chk("rr3_wen", 32'(wb.rf_write_en), 32'(RF_WRITE));
    tick();
    chk("noacc_wen", 32'(wb.rf_write_en), 32'(RF_NO_WRITE));

    // Single ALU request.
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd5; wb.req0_data = 32'hDEAD_BEEF;
    #1;
    chk("alu_rdy0", 32'(wb.req0_ready), 32'h1);
    chk("alu_rdy1", 32'(wb.req1_ready), 32'h0);
    tick();
    idle();
    chk("alu_wen", 32'(wb.rf_write_en), 32'(RF_WRITE));
    chk("alu_addr", 32'(wb.rf_write_addr), 32'd5);
    chk("alu_data", wb.rf_data, 32'hDEAD_BEEF);

    // Single LSU request.
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd12; wb.req1_data = 32'h1234_5678;
    #1;
    chk("lsu_rdy1", 32'(wb.req1_ready), 32'h1);
    chk("lsu_rdy0", 32'(wb.req0_ready), 32'h0);
    tick();
    idle();
    chk("lsu_data", wb.rf_data, 32'h1234_5678);

    // Mark 7, then clear via ALU writeback.
    mark_valid = 1'b1; mark_addr = 5'd7; query_addr1 = 5'd7;
    #1;
    chk("m7_before", 32'(busy1), 32'h0);
    tick();
    idle();
    chk("m7_busy", 32'(busy1), 32'(SB));
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd7; wb.req0_data = 32'h77;
    #1;
    chk("m7_still", 32'(busy1), 32'(SB));
    tick();
    idle();
    chk("m7_clr", 32'(busy1), 32'h0);
    chk("m7_addr", 32'(wb.rf_write_addr), 32'd7);

    // Mark 9, then mark and LSU clear of 9 together: mark wins.
    mark_valid = 1'b1; mark_addr = 5'd9; query_addr2 = 5'd9;
    tick();
    chk("m9_busy", 32'(busy2), 32'(SB));
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd9; wb.req1_data = 32'h99;
    #1;
    chk("m9_rdy1", 32'(wb.req1_ready), 32'h1);
    tick();
    idle();
    chk("m9_keep", 32'(busy2), 32'(SB));
    chk("m9_addr", 32'(wb.rf_write_addr), 32'd9);

    // Writeback to x0 accepted but not written; marking x0 ignored.
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd0; wb.req0_data = 32'h1;
    mark_valid = 1'b1; mark_addr = 5'd0; query_addr1 = 5'd0;
    #1;
    chk("x0_rdy0", 32'(wb.req0_ready), 32'h1);
    tick();
    idle();
    chk("x0_wen", 32'(wb.rf_write_en), 32'(RF_NO_WRITE));
    chk("x0_busy", 32'(busy1), 32'h0);

    // Reset with an accepted request and reg 4 pending.
    mark_valid = 1'b1; mark_addr = 5'd4; query_addr1 = 5'd4;
    tick();
    idle();
    chk("m4_busy", 32'(busy1), 32'(SB));
    rst = 1'b1;
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd3; wb.req0_data = 32'h5;
    #1;
    chk("rstacc_rdy0", 32'(wb.req0_ready), 32'h1);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("rstacc_wen", 32'(wb.rf_write_en), 32'(RF_NO_WRITE));
    chk("rstacc_addr", 32'(wb.rf_write_addr), 32'h0);
    chk("rstacc_busy4", 32'(busy1), 32'h0);

    // Pointer back at req0 after reset: LSU wins a tie.
    wb.req0_valid = 1'b1; wb.req1_valid = 1'b1;
    #1;
    chk("rst_rr_rdy1", 32'(wb.req1_ready), 32'h1);
    chk("rst_rr_rdy0", 32'(wb.req0_ready), 32'h0);
    tick();
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
